// File: rtl/core_pkg.sv
// Shared core definitions: feature record, register-count helper and
// the port-count limits for the register file.
package core_pkg;

  typedef struct packed {
    int unsigned WIDTH;
    int unsigned REG_ADDR;
  } alu_feature_t;

  localparam alu_feature_t RV32D = '{WIDTH: 32, REG_ADDR: 5};

  localparam int REGFILE_MIN_PORTS = 1;
  localparam int REGFILE_MAX_READ  = 4;
  localparam int REGFILE_MAX_WRITE = 2;

  function automatic int num_reg(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy tracking for the register file: reservations set, writes release,
// and operand-ready flags for each read port.
module regfile_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_REG    = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 3,
  parameter int NUM_WRITE  = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                                 clk_i,
  input  logic                                 arst_ni,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  raddr_i,
  input  logic [NUM_READ-1:0]                  ren_i,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WRITE-1:0]                 wen_i,
  input  logic [ADDR_WIDTH-1:0]                rsv_addr_i,
  input  logic                                 rsv_en_i,
  output logic [NUM_READ-1:0]                  rready_o,
  output logic [NUM_REG-1:0]                   busy_o
);

  logic [NUM_REG-1:0] busy_q;
  logic [NUM_REG-1:0] busy_d;

  // Release first, then reserve: a new producer in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wen_i[w]) busy_d[waddr_i[w]] = 1'b0;
    end
    if (rsv_en_i && !(ZERO_REG != 0 && rsv_addr_i == '0)) busy_d[rsv_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!arst_ni) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  // A write landing this cycle makes its value available through the bypass.
  always_comb begin
    rready_o = '1;
    for (int r = 0; r < NUM_READ; r++) begin
      if (ren_i[r] && !(ZERO_REG != 0 && raddr_i[r] == '0)) begin
        rready_o[r] = !busy_q[raddr_i[r]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WRITE; w++) begin
            if (wen_i[w] && waddr_i[w] == raddr_i[r]) rready_o[r] = 1'b1;
          end
        end
      end
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write priority, same-cycle bypass,
// write-collision flag and an integrated busy scoreboard.
module regfile_mp
  import core_pkg::*;
#(
  parameter alu_feature_t FEATURES = RV32D,
  parameter int DATA_WIDTH = int'(FEATURES.WIDTH),
  parameter int ADDR_WIDTH = int'(FEATURES.REG_ADDR),
  parameter int NUM_READ   = 3,
  parameter int NUM_WRITE  = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                                 clk_i,
  input  logic                                 arst_ni,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  raddr_i,
  input  logic [NUM_READ-1:0]                  ren_i,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic [NUM_READ-1:0]                  rready_o,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WRITE-1:0]                 wen_i,
  input  logic [ADDR_WIDTH-1:0]                rsv_addr_i,
  input  logic                                 rsv_en_i,
  output logic [num_reg(ADDR_WIDTH)-1:0]       busy_o,
  output logic                                 wconflict_o
);

  localparam int NUM_REG = num_reg(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REG];
  logic [NUM_WRITE-1:0]  wen_eff;
  logic                  conflict;
  logic                  wconflict_q;

  // Writes to a hardwired zero register are dropped before anything sees them.
  always_comb begin
    wen_eff = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      wen_eff[w] = wen_i[w] && !(ZERO_REG != 0 && waddr_i[w] == '0);
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_WRITE; i++) begin
      for (int j = i + 1; j < NUM_WRITE; j++) begin
        if (wen_i[i] && wen_i[j] && waddr_i[i] == waddr_i[j]) conflict = 1'b1;
      end
    end
  end

  // Later loop iterations override earlier ones, so the highest port wins.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      for (int i = 0; i < NUM_REG; i++) regs_q[i] <= '0;
      wconflict_q <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wen_eff[w]) regs_q[waddr_i[w]] <= wdata_i[w];
      end
      wconflict_q <= conflict;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      if (ren_i[r] && !(ZERO_REG != 0 && raddr_i[r] == '0)) begin
        rdata_o[r] = regs_q[raddr_i[r]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WRITE; w++) begin
            if (wen_eff[w] && waddr_i[w] == raddr_i[r]) rdata_o[r] = wdata_i[w];
          end
        end
      end
    end
  end

  assign wconflict_o = wconflict_q;

  regfile_scoreboard #(
    .NUM_REG   (NUM_REG),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_READ  (NUM_READ),
    .NUM_WRITE (NUM_WRITE),
    .BYPASS    (BYPASS),
    .ZERO_REG  (ZERO_REG)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .raddr_i   (raddr_i),
    .ren_i     (ren_i),
    .waddr_i   (waddr_i),
    .wen_i     (wen_eff),
    .rsv_addr_i(rsv_addr_i),
    .rsv_en_i  (rsv_en_i),
    .rready_o  (rready_o),
    .busy_o    (busy_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one
// registered-read instance share the same stimulus.
module tb_regfile_mp;

  logic             clk;
  logic             arst_ni;
  logic [2:0][4:0]  raddr;
  logic [2:0]       ren;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;
  logic [1:0]       wen;
  logic [4:0]       rsv_addr;
  logic             rsv_en;

  logic [2:0][31:0] rdata_b, rdata_n;
  logic [2:0]       rready_b, rready_n;
  logic [31:0]      busy_b, busy_n;
  logic             wconf_b, wconf_n;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_q[$];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_dut (
    .clk_i(clk), .arst_ni(arst_ni), .raddr_i(raddr), .ren_i(ren),
    .rdata_o(rdata_b), .rready_o(rready_b), .waddr_i(waddr), .wdata_i(wdata),
    .wen_i(wen), .rsv_addr_i(rsv_addr), .rsv_en_i(rsv_en), .busy_o(busy_b),
    .wconflict_o(wconf_b)
  );

  regfile_mp #(.BYPASS(0)) u_dut_nobyp (
    .clk_i(clk), .arst_ni(arst_ni), .raddr_i(raddr), .ren_i(ren),
    .rdata_o(rdata_n), .rready_o(rready_n), .waddr_i(waddr), .wdata_i(wdata),
    .wen_i(wen), .rsv_addr_i(rsv_addr), .rsv_en_i(rsv_en), .busy_o(busy_n),
    .wconflict_o(wconf_n)
  );

  // Driver tasks
  task automatic idle();
    ren = '0; raddr = '0; wen = '0; waddr = '0; wdata = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    arst_ni = 1'b0;
    step(); step();
    arst_ni = 1'b1;
    ren = 3'b111;
    for (int i = 0; i < 32; i++) begin
      raddr[0] = 5'(i); raddr[1] = 5'((i + 11) % 32); raddr[2] = 5'((i + 22) % 32);
      #1;
      tests_run++;
      if (rdata_b !== '0 || rready_b !== 3'b111) begin
        tests_failed++;
        $display("FAIL reset_read reg %0d: rdata=%h rready=%b, want 0 / 111", i, rdata_b, rready_b);
      end
    end
    tests_run++;
    if (busy_b !== '0 || wconf_b !== 1'b0 || busy_n !== '0) begin
      tests_failed++;
      $display("FAIL reset_busy: busy=%h wconf=%b, want 0 / 0", busy_b, wconf_b);
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    wen[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF;
    ren[1] = 1'b1; raddr[1] = 5'd5;
    #1;
    tests_run++;
    if (rdata_b[1] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: got %h want deadbeef", rdata_b[1]);
    end
    tests_run++;
    if (rdata_n[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL nobypass_same_cycle: got %h want 00000000", rdata_n[1]);
    end
    step();
    wen = '0;
    #1;
    tests_run++;
    if (rdata_b[1] !== 32'hDEADBEEF || rdata_n[1] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL write_next_cycle: byp=%h nobyp=%h want deadbeef", rdata_b[1], rdata_n[1]);
    end
    idle();
  endtask

  task automatic test_conflict();
    idle();
    wen = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
    wdata[0] = 32'h11111111; wdata[1] = 32'h22222222;
    ren[2] = 1'b1; raddr[2] = 5'd7;
    #1;
    tests_run++;
    if (wconf_b !== 1'b0 || rdata_b[2] !== 32'h22222222) begin
      tests_failed++;
      $display("FAIL conflict_same_cycle: wconf=%b rdata=%h want 0 / 22222222", wconf_b, rdata_b[2]);
    end
    step();
    wen = '0;
    #1;
    tests_run++;
    if (wconf_b !== 1'b1 || rdata_b[2] !== 32'h22222222 || rdata_n[2] !== 32'h22222222) begin
      tests_failed++;
      $display("FAIL conflict_winner: wconf=%b rdata=%h want 1 / 22222222", wconf_b, rdata_b[2]);
    end
    step();
    tests_run++;
    if (wconf_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL conflict_pulse_width: wconf=%b want 0", wconf_b);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    step();
    rsv_en = 1'b0;
    ren[0] = 1'b1; raddr[0] = 5'd9;
    #1;
    tests_run++;
    if (rready_b[0] !== 1'b0 || busy_b[9] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reserve_busy: rready=%b busy9=%b want 0 / 1", rready_b[0], busy_b[9]);
    end
    step();
    tests_run++;
    if (rready_b[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reserve_hold: rready=%b want 0", rready_b[0]);
    end
    wen[1] = 1'b1; waddr[1] = 5'd9; wdata[1] = 32'h0000CAFE;
    #1;
    tests_run++;
    if (rready_b[0] !== 1'b1 || rdata_b[0] !== 32'h0000CAFE) begin
      tests_failed++;
      $display("FAIL release_bypass: rready=%b rdata=%h want 1 / 0000cafe", rready_b[0], rdata_b[0]);
    end
    tests_run++;
    if (rready_n[0] !== 1'b0 || rdata_n[0] !== 32'h0) begin
      tests_failed++;
      $display("FAIL release_nobypass: rready=%b rdata=%h want 0 / 0", rready_n[0], rdata_n[0]);
    end
    step();
    wen = '0;
    #1;
    tests_run++;
    if (busy_b[9] !== 1'b0 || rready_b[0] !== 1'b1 || rdata_n[0] !== 32'h0000CAFE) begin
      tests_failed++;
      $display("FAIL release_after: busy9=%b rready=%b rdata=%h want 0 / 1 / 0000cafe",
               busy_b[9], rready_b[0], rdata_n[0]);
    end
    idle();
  endtask

  task automatic test_rsv_write_same();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    wen[0] = 1'b1; waddr[0] = 5'd3; wdata[0] = 32'h33333333;
    step();
    idle();
    ren[0] = 1'b1; raddr[0] = 5'd3;
    #1;
    tests_run++;
    if (busy_b[3] !== 1'b1 || rdata_b[0] !== 32'h33333333 || rready_b[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsv_write_same: busy3=%b rdata=%h rready=%b want 1 / 33333333 / 0",
               busy_b[3], rdata_b[0], rready_b[0]);
    end
    wen[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'h0000FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    ren[1] = 1'b1; raddr[1] = 5'd0;
    #1;
    tests_run++;
    if (rdata_b[1] !== 32'h0 || rready_b[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_reg_bypass: rdata=%h rready=%b want 0 / 1", rdata_b[1], rready_b[1]);
    end
    step();
    wen = '0; rsv_en = 1'b0;
    #1;
    tests_run++;
    if (rdata_b[1] !== 32'h0 || busy_b[0] !== 1'b0 || busy_b[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_reg_hold: rdata=%h busy0=%b busy3=%b want 0 / 0 / 1",
               rdata_b[1], busy_b[0], busy_b[3]);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    wen[0] = 1'b1; waddr[0] = 5'd4; wdata[0] = 32'h44444444;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    arst_ni = 1'b0;
    step();
    arst_ni = 1'b1;
    idle();
    ren[0] = 1'b1; raddr[0] = 5'd4;
    ren[1] = 1'b1; raddr[1] = 5'd5;
    #1;
    tests_run++;
    if (rdata_b[0] !== 32'h0 || rdata_b[1] !== 32'h0 || busy_b !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: reg4=%h reg5=%h busy=%h want 0 / 0 / 0", rdata_b[0], rdata_b[1], busy_b);
    end
    wen[0] = 1'b1; waddr[0] = 5'd4; wdata[0] = 32'h44444444;
    step();
    wen = '0;
    #1;
    tests_run++;
    if (rdata_n[0] !== 32'h44444444) begin
      tests_failed++;
      $display("FAIL reset_resume: reg4=%h want 44444444", rdata_n[0]);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    idle();
    for (int i = 0; i < 4; i++) begin
      wen = 2'b11;
      waddr[0] = 5'(16 + 2 * i); wdata[0] = 32'hA5000000 | 32'(16 + 2 * i);
      waddr[1] = 5'(17 + 2 * i); wdata[1] = 32'h5A000000 | 32'(17 + 2 * i);
      exp_q.push_back(32'hA5000000 | 32'(16 + 2 * i));
      exp_q.push_back(32'h5A000000 | 32'(17 + 2 * i));
      step();
    end
    idle();
    ren[2] = 1'b1;
    for (int i = 16; i < 24; i++) begin
      raddr[2] = 5'(i);
      #1;
      exp = exp_q.pop_front();
      tests_run++;
      if (rdata_b[2] !== exp || rdata_n[2] !== exp || rready_b[2] !== 1'b1) begin
        tests_failed++;
        $display("FAIL back_to_back reg %0d: got %h / %h rready=%b want %h / 1",
                 i, rdata_b[2], rdata_n[2], rready_b[2], exp);
      end
    end
    raddr[2] = 5'd24;
    #1;
    tests_run++;
    if (rdata_b[2] !== 32'h0) begin
      tests_failed++;
      $display("FAIL back_to_back_neighbour: reg24=%h want 0", rdata_b[2]);
    end
    idle();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    arst_ni = 1'b0;
    idle();
    test_reset();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_rsv_write_same();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file with an integrated scoreboard. It is the successor to the single-write, two-read core register file. It adds:
- configurable read and write port counts
- same-cycle write-to-read bypass
- deterministic write-port priority
- per-register busy tracking, so issue logic can stall on pending writes

It sits between the decode/issue stage (reads, reservations) and the writeback stage (writes, busy release).

Parameters:
FEATURES, core_pkg::RV32D, core feature record; supplies the width defaults below
DATA_WIDTH, FEATURES.WIDTH, register width in bits
ADDR_WIDTH, FEATURES.REG_ADDR, register address width; NUM_REG = 2**ADDR_WIDTH
NUM_READ, 3, number of read ports (1..4)
NUM_WRITE, 2, number of write ports (1..2)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see registered state only
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
clk_i  in  1  clock, rising edge
arst_ni  in  1  reset, synchronous, active-low
raddr_i  in  NUM_READ x ADDR_WIDTH  read addresses
ren_i  in  NUM_READ  read enables
rdata_o  out  NUM_READ x DATA_WIDTH  read data
rready_o  out  NUM_READ  operand available (not pending)
waddr_i  in  NUM_WRITE x ADDR_WIDTH  write addresses
wdata_i  in  NUM_WRITE x DATA_WIDTH  write data
wen_i  in  NUM_WRITE  write enables; each write also releases busy
rsv_addr_i  in  ADDR_WIDTH  destination being reserved by issue
rsv_en_i  in  1  reservation strobe
busy_o  out  NUM_REG  registered busy vector
wconflict_o  out  1  registered pulse: two enabled writes hit the same address last cycle

Behaviour:
Reset:
- One clock, clk_i; arst_ni is synchronous, active-low, sampled on the rising edge.
- While arst_ni=0 at an edge: all registers <= 0, busy <= 0, wconflict_o <= 0.
- Reset asserted mid-operation discards any same-cycle write or reservation.
- After reset: rdata_o = 0 (or enable-gated 0), rready_o = all 1, busy_o = 0.

Read path (combinational, 0-cycle latency):
- ren_i[r]=0 -> rdata_o[r] = 0 and rready_o[r] = 1.
- Otherwise rdata_o[r] = reg[raddr_i[r]].
- If BYPASS=1 and an enabled write targets raddr_i[r] this cycle, rdata_o[r] = the winning write data.
- ZERO_REG=1 and raddr_i[r]=0 -> rdata_o[r] = 0 and rready_o[r] = 1.

Write path (registered, visible next cycle):
- Each enabled port updates reg[waddr] at the edge.
- Same-address collision: the highest-index port wins, and wconflict_o = 1 for exactly the following cycle.
- Writes to register 0 are dropped when ZERO_REG=1.

Scoreboard:
- rsv_en_i sets busy[rsv_addr_i] at the edge.
- An enabled write clears busy[waddr] at the edge.
- Reservation and write to the same address in the same cycle -> busy = 1 (the new producer wins).
- Reservation of register 0 is ignored when ZERO_REG=1.
- rready_o[r] = !busy[raddr_i[r]], with one exception: when BYPASS=1 and a same-cycle write targets that address, rready_o[r] = 1.
- Re-reserving an already-busy register keeps it busy; no error.

Width rules:
- No arithmetic; all data passes unmodified.
- Addresses span the full 2**ADDR_WIDTH range with no wrap.

Decomposition:
- core_pkg: alu_feature_t, RV32D (WIDTH=32, REG_ADDR=5), NUM_REG derivation function, regfile port-count limits.
- Sub-module regfile_scoreboard: busy vector, reservation/release priority, rready_o generation. It takes decoded write enables and addresses from the parent.
- The parent holds storage, the write-priority resolver, bypass muxes and conflict detection.

Test Plan:
- Reset then read all 32 registers on 3 ports -> rdata_o = 0, rready_o = 3'b111, busy_o = 0.
- Write port0 reg5=0xDEADBEEF, read reg5 on port1 the same cycle:
  - BYPASS=1 -> 0xDEADBEEF in the same cycle.
  - BYPASS=0 -> 0 in that cycle, 0xDEADBEEF on the next.
- Both write ports target reg7 (0x11111111 on port0, 0x22222222 on port1) -> reg7 = 0x22222222, wconflict_o high for one cycle.
- Reserve reg9, then read reg9 -> rready_o = 0 until a write to reg9 = 0xCAFE. With BYPASS=1, rready_o = 1 and data 0xCAFE in the write cycle; busy_o[9] = 0 afterwards.
- Reserve and write reg3 in the same cycle -> busy_o[3] = 1 next cycle and reg3 holds the write data. Write reg0=0xFFFF and reserve reg0 -> reg0 reads 0, busy_o[0] = 0.
- Issue writes to reg4 and reservations on reg12 with arst_ni low in the same cycle -> the next cycle shows reg4 = 0 and busy_o = 0. Normal writes resume once arst_ni returns high.
